// File: rtl/divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one
// quotient bit per clock, signs applied in a final fix-up cycle. Latency is
// fixed at WIDTH+1 clocks from the accept edge, including divide-by-zero.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// RUN   | WIDTH restoring steps, one quotient bit per clock
// FIX   | apply signs, register results, pulse done

module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    if (WIDTH < 2) begin : g_bad_width
        $error("divider: WIDTH must be at least 2");
    end

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_by_zero_q, div_by_zero_d;

    // Magnitudes: negating the most negative value wraps to 2^(WIDTH-1),
    // which is exactly its magnitude when read as unsigned.
    logic [WIDTH-1:0] in1_mag;
    logic [WIDTH-1:0] in2_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quot_signed;
    logic [WIDTH-1:0] rem_signed;

    // Operand magnitudes, restoring trial subtraction and sign fix-up values.
    always_comb begin
        in1_mag     = in1[WIDTH-1] ? -in1 : in1;
        in2_mag     = in2[WIDTH-1] ? -in2 : in2;
        // Partial remainder stays below the divisor magnitude, so the shifted
        // value fits in WIDTH+1 bits and its top bit only feeds the borrow.
        shifted     = {rem_q, dq_q[WIDTH-1]};
        trial       = shifted - {1'b0, dvs_q};
        quot_signed = neg_quot_q ? -dq_q : dq_q;
        rem_signed  = neg_rem_q ? -rem_q : rem_q;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        rem_d         = rem_q;
        dq_d          = dq_q;
        dvs_d         = dvs_q;
        neg_quot_d    = neg_quot_q;
        neg_rem_d     = neg_rem_q;
        dbz_d         = dbz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dq_d       = in1_mag;
                    dvs_d      = in2_mag;
                    neg_rem_d  = in1[WIDTH-1];
                    neg_quot_d = in1[WIDTH-1] ^ in2[WIDTH-1];
                    dbz_d      = (in2 == '0);
                    rem_d      = '0;
                    count_d    = '0;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                end
                dq_d    = {dq_q[WIDTH-2:0], ~trial[WIDTH]};
                count_d = count_q + CW'(1);
                if (count_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // A zero divisor leaves |in1| as the remainder, so the signed
                // remainder is in1 itself; only the quotient needs forcing.
                quotient_d    = dbz_q ? '1 : quot_signed;
                remainder_d   = rem_signed;
                div_by_zero_d = dbz_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            rem_q         <= '0;
            dq_q          <= '0;
            dvs_q         <= '0;
            neg_quot_q    <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rem_q         <= rem_d;
            dq_q          <= dq_d;
            dvs_q         <= dvs_d;
            neg_quot_q    <= neg_quot_d;
            neg_rem_q     <= neg_rem_d;
            dbz_q         <= dbz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the signed sequential divider.

module tb_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int lat;
    int lat2;
    int bcyc;
    logic saw_done;

    divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in1         (in1),
        .in2         (in2),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive operands with start for one accept edge; returns #1 after it.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen (bounded) and how many samples had busy.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = busy ? 1 : 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_cyc++;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        start_op(a, b);
        wait_done(lat, bcyc);
        check({tag, " latency"}, 32'(lat), 32'd33);
        check({tag, " busy cycles"}, 32'(bcyc), 32'd33);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edbz});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        #23;
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("pos 100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        @(posedge clk);
        #1;
        check("done single pulse", {31'd0, done}, 32'd0);
        check("quotient hold", quotient, 32'd14);

        run_div("neg -100/7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_div("mix 100/-7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
        run_div("dbz 7/0", 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1);
        run_div("dbz -5/0", 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        run_div("ovf min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run_div("min/1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
        run_div("3/min", 32'd3, 32'h8000_0000, 32'd0, 32'd3, 1'b0);

        // Start while busy is ignored.
        start_op(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        in1   = 32'd9;
        in2   = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcyc);
        check("ignored start latency", 32'(lat + 10), 32'd33);
        check("ignored start quotient", quotient, 32'd14);
        check("ignored start remainder", remainder, 32'd2);

        // Start in the done cycle is accepted.
        start_op(32'd100, 32'd7);
        wait_done(lat, bcyc);
        check("b2b first quotient", quotient, 32'd14);
        in1   = 32'd9;
        in2   = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b done not repeated", {31'd0, done}, 32'd0);
        check("b2b busy after accept", {31'd0, busy}, 32'd1);
        wait_done(lat2, bcyc);
        check("b2b spacing", 32'(lat2 + 1), 32'd34);
        check("b2b quotient", quotient, 32'd3);
        check("b2b remainder", remainder, 32'd0);

        // Reset mid-operation.
        start_op(32'd100, 32'd7);
        repeat (11) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid reset quotient", quotient, 32'd0);
        check("mid reset remainder", remainder, 32'd0);
        check("mid reset busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("no done after reset", {31'd0, saw_done}, 32'd0);
        check("idle busy after reset", {31'd0, busy}, 32'd0);
        run_div("post reset 50/5", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
